cargador_programa: RTL and testbench
====================================

Name: cargador_programa

Overview:
Program loader that sits directly upstream of the 12-bit accumulator processor. It receives a framed byte stream over a valid/ready handshake and assembles 12-bit words. It writes those words into processor memory by driving the processor's wr/direccion/datoEntrante inputs, and holds the processor in reset until the image is validated. It then releases the processor to execute from address 0.

Parameters:
LARGO_DIRECCION, 6, processor memory address width
LARGO_DATO, 12, processor word width
MAX_PALABRAS, 64, largest legal word count in a frame

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
datoSerie  input  8  incoming frame byte
validoSerie  input  1  datoSerie valid
listoSerie  output  1  loader can accept a byte
wr  output  1  processor memory write enable
direccion  output  6  processor memory address
datoEntrante  output  12  word written into processor memory
resetProcesador  output  1  active-high reset driven to processor
cargaCompleta  output  1  image loaded and processor released
errorCarga  output  1  frame rejected
ocupado  output  1  frame in progress

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high.
- Reset values: wr=0, direccion=0, datoEntrante=0, resetProcesador=1, listoSerie=1, cargaCompleta=0, errorCarga=0, ocupado=0. State after reset is ESPERA.
- A byte is accepted on a rising edge where validoSerie=1 and listoSerie=1. No byte is consumed otherwise. All outputs are registered.
- Frame format: header N (1..64), then N words of two bytes each (high byte = {4'b0, word[11:8]}, low byte = word[7:0]), then a checksum byte. The checksum equals the 8-bit modulo-256 sum of the header and all word bytes.
- States:
  - ESPERA: listoSerie=1. If the header is 1..64: store N, clear sum/index, set ocupado=1 -> BYTE_ALTO. Otherwise -> ERROR.
  - BYTE_ALTO: listoSerie=1. If upper nibble is nonzero -> ERROR. Else latch the nibble -> BYTE_BAJO.
  - BYTE_BAJO: listoSerie=1. Latch the low byte -> ESCRIBE.
  - ESCRIBE: one cycle, listoSerie=0. Drive direccion=index and datoEntrante=word, and set wr=1 and resetProcesador=0 in the same edge. The processor writes on the next edge. Increment index. If index reaches N -> CHECKSUM, else -> BYTE_ALTO.
  - CHECKSUM: listoSerie=1. On match -> ARRANQUE. On mismatch -> ERROR.
  - ARRANQUE: one cycle, listoSerie=0. Set wr=0 and resetProcesador=1. Next edge: resetProcesador=0, cargaCompleta=1, ocupado=0 -> EJECUTA.
  - EJECUTA: listoSerie=1, processor runs. An accepted byte is treated as a new header. On that edge set resetProcesador=1, clear cargaCompleta, and handle the header as in ESPERA.
  - ERROR: errorCarga=1, wr=0, resetProcesador=1, ocupado=0, listoSerie=1. The next accepted byte clears errorCarga and is handled as a header.
- Once the first word is written, wr stays 1 until ARRANQUE. Between writes, direccion and datoEntrante hold the last word, so repeated writes are idempotent. wr=1 and resetProcesador=1 never occur on the same cycle.
- The checksum accumulator wraps modulo 256. The index counter is 7 bits so that N=64 completes correctly. N=64 writes addresses 0..63 and does not wrap.
- Bytes from a truncated frame are held indefinitely; there is no timeout. Asserting reset at any point returns the block to ESPERA with reset values, including mid-frame.

Test Plan:
- Happy path: send 0x02, 0x01, 0x05, 0x00, 0x10, 0x18 -> two wr writes: addr0=0x105, then addr1=0x010. A one-cycle resetProcesador pulse with wr=0 follows. Then cargaCompleta=1 and errorCarga=0.
- Bad checksum: send the same frame with checksum 0x19 -> errorCarga=1, resetProcesador stays 1, wr=0, and cargaCompleta never asserts.
- Illegal header: send 0x00, then separately 0x41 -> each goes to ERROR with no wr pulse. A following valid frame loads correctly and clears errorCarga.
- Bad high byte: send 0x01, 0x21 -> ERROR immediately and no memory write occurs.
- Backpressure and reload: hold validoSerie low for 5 cycles mid-word -> no progress and no spurious writes. After cargaCompleta, send a new frame 0x01, 0x0A, 0xBC, 0xC7 -> resetProcesador rises on header acceptance and addr0=0xABC is written.
- Max size and async reset: a 64-word frame writes addresses 0..63 and completes. Asserting reset after word 10 of a later frame clears all outputs immediately, with no further wr.

Source files
------------

// File: rtl/cargador_programa.sv
// Program loader: receives a framed byte stream, writes 12-bit words into the
// accumulator processor's memory and releases the processor once the checksum is validated.
module cargador_programa #(
    parameter int unsigned LARGO_DIRECCION = 6,
    parameter int unsigned LARGO_DATO      = 12,
    parameter int unsigned MAX_PALABRAS    = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 datoSerie,
    input  logic                       validoSerie,
    output logic                       listoSerie,
    output logic                       wr,
    output logic [LARGO_DIRECCION-1:0] direccion,
    output logic [LARGO_DATO-1:0]      datoEntrante,
    output logic                       resetProcesador,
    output logic                       cargaCompleta,
    output logic                       errorCarga,
    output logic                       ocupado
);

    // One spare bit on the index so a full-memory frame can reach its count.
    localparam int unsigned LARGO_INDICE = LARGO_DIRECCION + 1;
    localparam int unsigned LARGO_ALTO   = LARGO_DATO - 8;

    typedef enum logic [2:0] {
        ESPERA,
        BYTE_ALTO,
        BYTE_BAJO,
        ESCRIBE,
        CHECKSUM,
        ARRANQUE,
        EJECUTA,
        ERROR
    } estado_t;

    estado_t                 estado;
    logic [LARGO_INDICE-1:0] indice;
    logic [LARGO_INDICE-1:0] total;
    logic [LARGO_INDICE-1:0] indice_sig;
    logic [7:0]              suma;
    logic [LARGO_ALTO-1:0]   alto;
    logic [7:0]              bajo;
    logic                    acepta;
    logic                    header_ok;

    assign acepta     = validoSerie && listoSerie;
    assign header_ok  = (datoSerie != 8'd0) && (32'(datoSerie) <= MAX_PALABRAS);
    assign indice_sig = indice + LARGO_INDICE'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado          <= ESPERA;
            wr              <= 1'b0;
            direccion       <= '0;
            datoEntrante    <= '0;
            resetProcesador <= 1'b1;
            listoSerie      <= 1'b1;
            cargaCompleta   <= 1'b0;
            errorCarga      <= 1'b0;
            ocupado         <= 1'b0;
            indice          <= '0;
            total           <= '0;
            suma            <= '0;
            alto            <= '0;
            bajo            <= '0;
        end else begin
            case (estado)
                // Any idle state treats the next accepted byte as a frame header.
                ESPERA, EJECUTA, ERROR: begin
                    if (acepta) begin
                        resetProcesador <= 1'b1;
                        cargaCompleta   <= 1'b0;
                        wr              <= 1'b0;
                        errorCarga      <= !header_ok;
                        if (header_ok) begin
                            total   <= LARGO_INDICE'(datoSerie);
                            suma    <= datoSerie;
                            indice  <= '0;
                            ocupado <= 1'b1;
                            estado  <= BYTE_ALTO;
                        end else begin
                            ocupado <= 1'b0;
                            estado  <= ERROR;
                        end
                    end
                end
                BYTE_ALTO: begin
                    if (acepta) begin
                        if (datoSerie[7:LARGO_ALTO] != '0) begin
                            errorCarga      <= 1'b1;
                            wr              <= 1'b0;
                            resetProcesador <= 1'b1;
                            ocupado         <= 1'b0;
                            estado          <= ERROR;
                        end else begin
                            alto   <= datoSerie[LARGO_ALTO-1:0];
                            suma   <= suma + datoSerie;
                            estado <= BYTE_BAJO;
                        end
                    end
                end
                BYTE_BAJO: begin
                    if (acepta) begin
                        bajo       <= datoSerie;
                        suma       <= suma + datoSerie;
                        listoSerie <= 1'b0;
                        estado     <= ESCRIBE;
                    end
                end
                // wr then stays high; address/data hold so repeated writes are harmless.
                ESCRIBE: begin
                    wr              <= 1'b1;
                    resetProcesador <= 1'b0;
                    direccion       <= indice[LARGO_DIRECCION-1:0];
                    datoEntrante    <= {alto, bajo};
                    indice          <= indice_sig;
                    listoSerie      <= 1'b1;
                    estado          <= (indice_sig == total) ? CHECKSUM : BYTE_ALTO;
                end
                CHECKSUM: begin
                    if (acepta) begin
                        wr              <= 1'b0;
                        resetProcesador <= 1'b1;
                        if (datoSerie == suma) begin
                            listoSerie <= 1'b0;
                            estado     <= ARRANQUE;
                        end else begin
                            errorCarga <= 1'b1;
                            ocupado    <= 1'b0;
                            estado     <= ERROR;
                        end
                    end
                end
                ARRANQUE: begin
                    resetProcesador <= 1'b0;
                    cargaCompleta   <= 1'b1;
                    ocupado         <= 1'b0;
                    listoSerie      <= 1'b1;
                    estado          <= EJECUTA;
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule

// File: tb/tb_cargador_programa.sv
// Bench for cargador_programa: byte-stream driver, write scoreboard and per-scenario checks.
module tb_cargador_programa;

    logic        clk;
    logic        reset;
    logic [7:0]  datoSerie;
    logic        validoSerie;
    logic        listoSerie;
    logic        wr;
    logic [5:0]  direccion;
    logic [11:0] datoEntrante;
    logic        resetProcesador;
    logic        cargaCompleta;
    logic        errorCarga;
    logic        ocupado;

    int checks = 0;
    int errors = 0;

    logic [17:0] sb_q[$];
    logic [11:0] palabras [64];

    cargador_programa dut (
        .clk             (clk),
        .reset           (reset),
        .datoSerie       (datoSerie),
        .validoSerie     (validoSerie),
        .listoSerie      (listoSerie),
        .wr              (wr),
        .direccion       (direccion),
        .datoEntrante    (datoEntrante),
        .resetProcesador (resetProcesador),
        .cargaCompleta   (cargaCompleta),
        .errorCarga      (errorCarga),
        .ocupado         (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-write monitor: a new write is wr rising or the address moving while wr is held.
    logic       wr_prev = 1'b0;
    logic [5:0] dir_prev = 6'd0;
    always @(negedge clk) begin
        logic [17:0] esperado;
        checks++;
        if (wr && resetProcesador) begin
            errors++;
            $display("FAIL wr_reset_overlap: wr=%0b resetProcesador=%0b, required not both 1", wr, resetProcesador);
        end
        if (wr && (!wr_prev || direccion != dir_prev)) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%03h, required no write", direccion, datoEntrante);
            end else begin
                esperado = sb_q.pop_front();
                if ({direccion, datoEntrante} !== esperado) begin
                    errors++;
                    $display("FAIL write_data: addr=%0d data=%03h, required addr=%0d data=%03h",
                             direccion, datoEntrante, esperado[17:12], esperado[11:0]);
                end
            end
        end
        wr_prev  = wr;
        dir_prev = direccion;
    end

    // Called at a negedge; returns at the negedge after the byte was accepted, valid low.
    task automatic send_byte(input logic [7:0] b);
        int espera = 0;
        validoSerie = 1'b0;
        while (!listoSerie && espera < 50) begin
            @(negedge clk);
            espera++;
        end
        if (!listoSerie) begin
            checks++;
            errors++;
            $display("FAIL listo_timeout: listoSerie=%0b, required 1 within 50 cycles", listoSerie);
        end
        datoSerie   = b;
        validoSerie = 1'b1;
        @(negedge clk);
        validoSerie = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [7:0] delta_cs);
        logic [7:0] cs;
        cs = 8'(n);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            sb_q.push_back({6'(i), palabras[i]});
            send_byte({4'b0, palabras[i][11:8]});
            cs = cs + {4'b0, palabras[i][11:8]};
            send_byte(palabras[i][7:0]);
            cs = cs + palabras[i][7:0];
        end
        send_byte(cs + delta_cs);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        validoSerie = 1'b0;
        datoSerie   = 8'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({wr, direccion, datoEntrante, resetProcesador, listoSerie, cargaCompleta, errorCarga, ocupado}
            !== {1'b0, 6'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: wr=%0b dir=%0d dato=%03h rp=%0b listo=%0b cc=%0b err=%0b oc=%0b, required 0 0 000 1 1 0 0 0",
                     wr, direccion, datoEntrante, resetProcesador, listoSerie, cargaCompleta, errorCarga, ocupado);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_happy();
        palabras[0] = 12'h105;
        palabras[1] = 12'h010;
        send_frame(2, 8'd0);
        checks++;
        if ({resetProcesador, wr, listoSerie, cargaCompleta} !== 4'b1000) begin
            errors++;
            $display("FAIL happy_arranque: rp=%0b wr=%0b listo=%0b cc=%0b, required 1 0 0 0",
                     resetProcesador, wr, listoSerie, cargaCompleta);
        end
        @(negedge clk);
        checks++;
        if ({resetProcesador, cargaCompleta, errorCarga, ocupado, listoSerie} !== 5'b01001) begin
            errors++;
            $display("FAIL happy_done: rp=%0b cc=%0b err=%0b oc=%0b listo=%0b, required 0 1 0 0 1",
                     resetProcesador, cargaCompleta, errorCarga, ocupado, listoSerie);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL happy_writes: pending=%0d, required 0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h01);
        checks++;
        if ({resetProcesador, cargaCompleta, ocupado} !== 3'b101) begin
            errors++;
            $display("FAIL reload_header: rp=%0b cc=%0b oc=%0b, required 1 0 1", resetProcesador, cargaCompleta, ocupado);
        end
        sb_q.push_back({6'd0, 12'hABC});
        send_byte(8'h0A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({wr, ocupado, resetProcesador} !== 3'b011) begin
                errors++;
                $display("FAIL backpressure_idle: cycle=%0d wr=%0b oc=%0b rp=%0b, required 0 1 1", i, wr, ocupado, resetProcesador);
            end
        end
        send_byte(8'hBC);
        send_byte(8'hC7);
        @(negedge clk);
        checks++;
        if ({cargaCompleta, errorCarga, sb_q.size() == 0} !== 3'b101) begin
            errors++;
            $display("FAIL reload_done: cc=%0b err=%0b pending=%0d, required 1 0 0", cargaCompleta, errorCarga, sb_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        palabras[0] = 12'h105;
        palabras[1] = 12'h010;
        send_frame(2, 8'd1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({errorCarga, resetProcesador, wr, cargaCompleta, ocupado} !== 5'b11000) begin
                errors++;
                $display("FAIL bad_checksum: cycle=%0d err=%0b rp=%0b wr=%0b cc=%0b oc=%0b, required 1 1 0 0 0",
                         i, errorCarga, resetProcesador, wr, cargaCompleta, ocupado);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_header();
        send_byte(8'h00);
        checks++;
        if ({errorCarga, wr, ocupado} !== 3'b100) begin
            errors++;
            $display("FAIL header_zero: err=%0b wr=%0b oc=%0b, required 1 0 0", errorCarga, wr, ocupado);
        end
        send_byte(8'h41);
        checks++;
        if ({errorCarga, wr, ocupado} !== 3'b100) begin
            errors++;
            $display("FAIL header_65: err=%0b wr=%0b oc=%0b, required 1 0 0", errorCarga, wr, ocupado);
        end
        palabras[0] = 12'h3C5;
        send_frame(1, 8'd0);
        @(negedge clk);
        checks++;
        if ({cargaCompleta, errorCarga, sb_q.size() == 0} !== 3'b101) begin
            errors++;
            $display("FAIL header_recovery: cc=%0b err=%0b pending=%0d, required 1 0 0", cargaCompleta, errorCarga, sb_q.size());
        end
    endtask

    task automatic test_bad_high();
        send_byte(8'h01);
        send_byte(8'h21);
        @(negedge clk);
        checks++;
        if ({errorCarga, wr, ocupado, resetProcesador} !== 4'b1001) begin
            errors++;
            $display("FAIL bad_high: err=%0b wr=%0b oc=%0b rp=%0b, required 1 0 0 1", errorCarga, wr, ocupado, resetProcesador);
        end
    endtask

    task automatic test_max_and_reset();
        for (int i = 0; i < 64; i++) palabras[i] = 12'($urandom);
        send_frame(64, 8'd0);
        @(negedge clk);
        checks++;
        if ({cargaCompleta, errorCarga, sb_q.size() == 0} !== 3'b101) begin
            errors++;
            $display("FAIL max_frame: cc=%0b err=%0b pending=%0d, required 1 0 0", cargaCompleta, errorCarga, sb_q.size());
        end
        send_byte(8'd20);
        for (int i = 0; i < 10; i++) begin
            palabras[i] = 12'($urandom);
            sb_q.push_back({6'(i), palabras[i]});
            send_byte({4'b0, palabras[i][11:8]});
            send_byte(palabras[i][7:0]);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({wr, direccion, datoEntrante, resetProcesador, listoSerie, cargaCompleta, errorCarga, ocupado}
            !== {1'b0, 6'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: wr=%0b dir=%0d dato=%03h rp=%0b listo=%0b cc=%0b err=%0b oc=%0b, required 0 0 000 1 1 0 0 0",
                     wr, direccion, datoEntrante, resetProcesador, listoSerie, cargaCompleta, errorCarga, ocupado);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL truncated_writes: pending=%0d, required 0", sb_q.size());
        end
        palabras[0] = 12'h7FF;
        send_frame(1, 8'd0);
        @(negedge clk);
        checks++;
        if ({cargaCompleta, errorCarga, sb_q.size() == 0} !== 3'b101) begin
            errors++;
            $display("FAIL post_reset_frame: cc=%0b err=%0b pending=%0d, required 1 0 0", cargaCompleta, errorCarga, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_back_to_back();
        test_bad_checksum();
        test_illegal_header();
        test_bad_high();
        test_max_and_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: pending=%0d, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
